fetch_queue: RTL

//  Parametrised instruction-fetch front end for the pipelined core. It replaces the single PC/instruction

---
 rtl/fetch_queue_pkg.sv | 6 +
 rtl/fetch_queue_sync_fifo.sv | 54 +++++
 rtl/fetch_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch front end.
// Instruction size and the word shown on an empty queue.
package fetch_queue_pkg;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] FETCH_NOP   = 32'd0;
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush, count, full and empty.
// Generic enough to back the future load/store queue.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointers and occupancy; flush empties the queue at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Decoupled prefetch queue: issues sequential imem fetches,
// drops stale responses after a redirect, feeds decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  input  logic            imem_gnt_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] STEP =
    XLEN'(INSTR_BYTES);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic [2*XLEN-1:0] fifo_dout;
  logic [CW:0]       used;
  logic              grant, drop, push, pop;
  logic [XLEN-1:0]   tgt_pc;

  assign tgt_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign used   = {1'b0, fifo_cnt} + {1'b0, inflight_q};

  assign imem_req_o  = rst_n && !redirect_i &&
                       (used < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;
  assign drop        = imem_rvalid_i && (drop_q != '0);
  assign push        = imem_rvalid_i && !drop && !redirect_i;
  assign pop         = instr_valid_o && instr_ready_i &&
                       !redirect_i;

  assign instr_valid_o = !fifo_empty;
  assign instr_pc_o    = fifo_empty ? XLEN'(FETCH_NOP)
                                    : fifo_dout[2*XLEN-1:XLEN];
  assign instr_o       = fifo_empty ? XLEN'(FETCH_NOP)
                                    : fifo_dout[XLEN-1:0];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({rsp_pc_q, imem_rdata_i}),
    .data_o  (fifo_dout),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next PCs and credits; a redirect marks every
  // outstanding request (minus one answered now) stale.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(grant)
               - CW'(imem_rvalid_i);
    drop_d     = drop_q - CW'(drop);
    if (grant) fetch_pc_d = fetch_pc_q + STEP;
    if (push)  rsp_pc_d   = rsp_pc_q + STEP;
    if (redirect_i) begin
      fetch_pc_d = tgt_pc;
      rsp_pc_d   = tgt_pc;
      drop_d     = inflight_q - CW'(imem_rvalid_i);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // The credit scheme must never let a push hit a full queue.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && fifo_full));
  end
endmodule
